// File: rtl/softmax_pkg_16.sv
// softmax_pkg_16: shared state encoding and 1.7.8 constants for the 16-bit softmax front end
package softmax_pkg_16;
    typedef enum logic [1:0] {S_RECV, S_SUB, S_DONE} state_t;
    localparam int DATA_W_16 = 16;
    localparam int DEPTH_16 = 10;
    localparam int CNT_W_16 = 8;
    localparam logic [DATA_W_16-1:0] Q_MIN = 16'h8000;
    localparam logic [DATA_W_16-1:0] Q_ZERO = 16'h0000;
endpackage

// File: rtl/sat_sub_16.sv
// sat_sub_16: signed a - b; clamps to the most negative code when SUB_SATURATE_EN is defined, else wraps
module sat_sub_16 #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
`ifdef SUB_SATURATE_EN
    logic [W:0] d;
    assign d = {a[W-1], a} - {b[W-1], b};
    // b is the running max so a - b never exceeds zero; only the negative side can overflow
    assign y = (d[W] && !d[W-1]) ? {1'b1, {(W-1){1'b0}}} : d[W-1:0];
`else
    assign y = a - b;
`endif
endmodule

// File: rtl/axis_max_sub_in_16.sv
// axis_max_sub_in_16: buffers one AXIS frame, tracks its signed max, replays x - max (SUB_SATURATE_EN selects clamping)
module axis_max_sub_in_16
    import softmax_pkg_16::*;
#(
    parameter int data_size = DATA_W_16,
    parameter int depth = DEPTH_16,
    parameter int cnt_w = CNT_W_16
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [data_size-1:0] s_axis_data_i,
    input  logic                 s_axis_valid_i,
    input  logic                 s_axis_last_i,
    output logic                 s_axis_ready_o,
    output logic [data_size-1:0] exp_data_o,
    output logic                 exp_data_valid_o,
    output logic                 exp_sub_2_done_o,
    output logic [cnt_w-1:0]     frame_len_o,
    output logic                 overflow_o
);
    localparam int IW = $clog2(depth);
    state_t state;
    logic [data_size-1:0] mem [depth];
    logic [cnt_w-1:0] wr_cnt, rd_cnt;
    logic [data_size-1:0] max_q, diff;
    logic accept, close;
    assign accept = s_axis_valid_i && s_axis_ready_o;
    assign close = s_axis_last_i || wr_cnt == cnt_w'(depth - 1);
    sat_sub_16 #(.W(data_size)) u_sub (
        .a(mem[rd_cnt[IW-1:0]]),
        .b(max_q),
        .y(diff)
    );
    // receive, replay and wrap-up FSM with all outputs registered
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state <= S_RECV;
            wr_cnt <= '0;
            rd_cnt <= '0;
            max_q <= Q_MIN;
            for (int i = 0; i < depth; i++) mem[i] <= '0;
            s_axis_ready_o <= 1'b0;
            exp_data_o <= '0;
            exp_data_valid_o <= 1'b0;
            exp_sub_2_done_o <= 1'b0;
            frame_len_o <= '0;
            overflow_o <= 1'b0;
        end else begin
            case (state)
                S_RECV: begin
                    exp_sub_2_done_o <= 1'b0;
                    s_axis_ready_o <= 1'b1;
                    if (accept) begin
                        mem[wr_cnt[IW-1:0]] <= s_axis_data_i;
                        wr_cnt <= wr_cnt + 1'b1;
                        max_q <= ($signed(s_axis_data_i) > $signed(max_q)) ? s_axis_data_i : max_q;
                        if (close) begin
                            state <= S_SUB;
                            s_axis_ready_o <= 1'b0;
                            overflow_o <= overflow_o | ~s_axis_last_i;
                        end
                    end
                end
                S_SUB: begin
                    exp_data_o <= diff;
                    exp_data_valid_o <= 1'b1;
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_cnt == wr_cnt - 1'b1) state <= S_DONE;
                end
                S_DONE: begin
                    exp_data_valid_o <= 1'b0;
                    exp_sub_2_done_o <= 1'b1;
                    frame_len_o <= wr_cnt;
                    wr_cnt <= '0;
                    rd_cnt <= '0;
                    max_q <= Q_MIN;
                    state <= S_RECV;
                end
                default: state <= S_RECV;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_max_sub_in_16.sv
// tb_axis_max_sub_in_16: scoreboard bench for the AXIS max/subtract front end
module tb_axis_max_sub_in_16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] s_data = '0;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;
    logic s_ready;
    logic [15:0] e_data;
    logic e_valid;
    logic e_done;
    logic [7:0] f_len;
    logic ovf;
    logic [15:0] stim_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    logic [15:0] last_q[$];
    logic [15:0] acc_buf[$];
    int passes = 0;
    int total = 0;
    int done_cnt = 0;
    int coinc = 0;

    always #5 clk = ~clk;

    axis_max_sub_in_16 dut (
        .clock_i(clk),
        .reset_i(rst),
        .s_axis_data_i(s_data),
        .s_axis_valid_i(s_valid),
        .s_axis_last_i(s_last),
        .s_axis_ready_o(s_ready),
        .exp_data_o(e_data),
        .exp_data_valid_o(e_valid),
        .exp_sub_2_done_o(e_done),
        .frame_len_o(f_len),
        .overflow_o(ovf)
    );

    // collect DUT outputs away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (e_valid) obs_q.push_back(e_data);
            if (e_done) done_cnt++;
            if (e_valid && e_done) coinc++;
        end
    end

    function automatic logic [15:0] model_sub(input logic [15:0] x, input logic [15:0] m);
        logic signed [16:0] d;
        d = $signed({x[15], x}) - $signed({m[15], m});
`ifdef SUB_SATURATE_EN
        if (d < -17'sd32768) return 16'h8000;
`endif
        return d[15:0];
    endfunction

    task automatic close_frame();
        logic [15:0] m;
        m = 16'h8000;
        foreach (acc_buf[k]) if ($signed(acc_buf[k]) > $signed(m)) m = acc_buf[k];
        foreach (acc_buf[k]) exp_q.push_back(model_sub(acc_buf[k], m));
    endtask

    task automatic run_frame(input bit use_last, input bit hold, input int gap);
        bit acc, sent, closed;
        int tries;
        acc_buf.delete();
        closed = 1'b0;
        foreach (stim_q[i]) begin
            sent = 1'b0;
            tries = 0;
            while (!sent) begin
                if (gap > 0 && int'($urandom_range(0, 99)) < gap) begin
                    s_valid = 1'b0;
                    s_last = 1'($urandom_range(0, 1));
                    s_data = 16'hDEAD;
                    @(posedge clk); #1;
                end else begin
                    s_data = stim_q[i];
                    s_valid = 1'b1;
                    s_last = use_last && (i == stim_q.size() - 1);
                    acc = s_ready;
                    @(posedge clk); #1;
                    if (acc && !closed) begin
                        acc_buf.push_back(stim_q[i]);
                        if (s_last || acc_buf.size() == 10) begin
                            closed = 1'b1;
                            close_frame();
                        end
                    end
                    sent = acc || !hold;
                end
                tries++;
                if (tries > 60) begin
                    total++;
                    $display("FAIL beat_accept: beat %0d not accepted after %0d cycles", i, tries);
                    sent = 1'b1;
                end
            end
        end
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int d0, n;
        bit seen;
        logic [15:0] o, x;
        d0 = done_cnt;
        seen = 1'b0;
        last_q.delete();
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk); #1;
            if (done_cnt != d0) seen = 1'b1;
        end
        total++;
        if (!seen) $display("FAIL %s_done: done pulse count %0d, required %0d", name, done_cnt - d0, 1);
        else passes++;
        total++;
        if (s_ready !== 1'b1) $display("FAIL %s_ready_after_done: got %b, required 1", name, s_ready);
        else passes++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (done_cnt - d0 != 1) $display("FAIL %s_done_width: got %0d pulses, required 1", name, done_cnt - d0);
        else passes++;
        total++;
        if (coinc != 0) $display("FAIL %s_done_with_valid: got %0d overlaps, required 0", name, coinc);
        else passes++;
        n = exp_q.size();
        total++;
        if (obs_q.size() != n) $display("FAIL %s_count: got %0d outputs, required %0d", name, obs_q.size(), n);
        else passes++;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
            last_q.push_back(o);
            total++;
            if (o !== x) $display("FAIL %s_data: got %h, required %h", name, o, x);
            else passes++;
        end
        obs_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if ({s_ready, e_valid, e_done, ovf} !== 4'b0 || e_data !== 16'h0 || f_len !== 8'h0)
            $display("FAIL reset_outputs: ready=%b valid=%b done=%b ovf=%b data=%h len=%0d, required all 0",
                     s_ready, e_valid, e_done, ovf, e_data, f_len);
        else passes++;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (s_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", s_ready);
        else passes++;
    endtask

    task automatic test_basic();
        stim_q = '{16'h0100, 16'h0300, 16'h0200};
        run_frame(1'b1, 1'b1, 0);
        wait_frame("basic");
        total++;
        if (last_q.size() != 3 || last_q[0] !== 16'hFE00 || last_q[1] !== 16'h0000 || last_q[2] !== 16'hFF00)
            $display("FAIL basic_values: got %p, required FE00 0000 FF00", last_q);
        else passes++;
        total++;
        if (f_len !== 8'd3) $display("FAIL basic_len: got %0d, required 3", f_len);
        else passes++;
        total++;
        if (ovf !== 1'b0) $display("FAIL basic_ovf: got %b, required 0", ovf);
        else passes++;
    endtask

    task automatic test_single();
        stim_q = '{16'hF000};
        run_frame(1'b1, 1'b1, 0);
        wait_frame("single");
        total++;
        if (f_len !== 8'd1) $display("FAIL single_len: got %0d, required 1", f_len);
        else passes++;
        total++;
        if (ovf !== 1'b0) $display("FAIL single_ovf: got %b, required 0", ovf);
        else passes++;
    endtask

    task automatic test_back_to_back();
        stim_q = '{16'hFF80, 16'h0040};
        run_frame(1'b1, 1'b1, 0);
        wait_frame("b2b_a");
        stim_q = '{16'h0200, 16'hFE00, 16'h0180, 16'h0200};
        run_frame(1'b1, 1'b1, 0);
        wait_frame("b2b_b");
        total++;
        if (f_len !== 8'd4) $display("FAIL b2b_len: got %0d, required 4", f_len);
        else passes++;
    endtask

    task automatic test_overflow();
        stim_q.delete();
        for (int i = 0; i < 12; i++) stim_q.push_back(16'(16'h0010 * (i + 1)));
        run_frame(1'b0, 1'b0, 0);
        total++;
        if (acc_buf.size() != 10) $display("FAIL ovf_accepted: got %0d beats, required 10", acc_buf.size());
        else passes++;
        wait_frame("ovf");
        total++;
        if (f_len !== 8'd10) $display("FAIL ovf_len: got %0d, required 10", f_len);
        else passes++;
        total++;
        if (ovf !== 1'b1) $display("FAIL ovf_flag: got %b, required 1", ovf);
        else passes++;
    endtask

    task automatic test_extremes();
        stim_q = '{16'h8000, 16'h7FFF};
        run_frame(1'b1, 1'b1, 0);
        wait_frame("extreme");
    endtask

    task automatic test_mid_reset();
        int d0;
        bit got;
        logic [15:0] x0, x1;
        stim_q = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        run_frame(1'b1, 1'b1, 0);
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(posedge clk); #1;
            if (obs_q.size() >= 2) got = 1'b1;
        end
        total++;
        if (!got) $display("FAIL midrst_outputs: got %0d outputs, required 2", obs_q.size());
        else passes++;
        d0 = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (e_valid !== 1'b0) $display("FAIL midrst_valid: got %b, required 0", e_valid);
        else passes++;
        x0 = exp_q.pop_front();
        x1 = exp_q.pop_front();
        total++;
        if (obs_q.size() < 2 || obs_q[0] !== x0 || obs_q[1] !== x1)
            $display("FAIL midrst_prefix: got %p, required %h %h", obs_q, x0, x1);
        else passes++;
        exp_q.delete();
        obs_q.delete();
        for (int c = 0; c < 20; c++) begin @(posedge clk); #1; end
        total++;
        if (done_cnt != d0 || obs_q.size() != 0)
            $display("FAIL midrst_quiet: got %0d done pulses and %0d outputs, required 0 and 0",
                     done_cnt - d0, obs_q.size());
        else passes++;
        stim_q = '{16'h0080};
        run_frame(1'b1, 1'b1, 0);
        wait_frame("midrst_next");
        total++;
        if (last_q.size() != 1 || last_q[0] !== 16'h0000)
            $display("FAIL midrst_next_value: got %p, required 0000", last_q);
        else passes++;
    endtask

    task automatic test_gaps();
        logic [15:0] ref_q[$];
        stim_q = '{16'h0123, 16'hFE40, 16'h0a00, 16'hF800, 16'h0a01, 16'h0000, 16'hFFFF, 16'h0555};
        run_frame(1'b1, 1'b1, 0);
        wait_frame("nogap");
        ref_q = last_q;
        run_frame(1'b1, 1'b1, 40);
        wait_frame("gap");
        total++;
        if (last_q != ref_q) $display("FAIL gap_vs_nogap: got %p, required %p", last_q, ref_q);
        else passes++;
        total++;
        if (f_len !== 8'd8) $display("FAIL gap_len: got %0d, required 8", f_len);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_back_to_back();
        test_gaps();
        test_overflow();
        test_extremes();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
